pci_blue_delayed_read_ctrl: RTL and testbench
=============================================

Name: pci_blue_delayed_read_ctrl

Overview:
Sequences the single Delayed Read that the PCI Target can hold outstanding (PCI 2.2 sections 3.3.3.3 and 3.7.5).
- Latches the first read request and retries the external master.
- Issues the SRAM read request toward the host through the Response FIFO path.
- Waits for returned data plus a write fence, then lets the matching retried read complete.
- Flushes and restarts on write collision, and discards abandoned data on timeout.
- Sits between the Target state machine and the Response and Delayed Read Data FIFO interfaces.

Parameters:
DISCARD_CYCLES, 32768, clocks in READY without a matching retry before the data is discarded (PCI discard timer, 2^15).
TIMER_WIDTH, 16, width of the discard counter; must satisfy 2^TIMER_WIDTH > DISCARD_CYCLES.

Ports:
pci_clk  input  1  PCI clock; all logic on rising edge.
pci_reset_comb  input  1  synchronous, active-high reset.
tgt_read_req  input  1  one-cycle pulse; Target decoded a memory read.
tgt_read_address  input  32  address of tgt_read_req.
tgt_read_command  input  4  PCI command of tgt_read_req.
tgt_read_cbe  input  4  first-data byte enables of tgt_read_req.
tgt_write_seen  input  1  one-cycle pulse; Target accepted a memory write.
tgt_read_done  input  1  one-cycle pulse; Target finished delivering Delayed Read data.
dr_resp_valid  output  1  one-cycle pulse answering tgt_read_req.
dr_resp_hit  output  1  valid with dr_resp_valid: 1 = deliver data, 0 = signal Retry.
host_read_issue  output  1  level request to enqueue the SRAM read.
host_read_issue_ack  input  1  host accepted the enqueue.
host_read_address  output  32  latched address.
host_read_command  output  4  latched command.
host_read_cbe  output  4  latched byte enables.
delayed_read_data_available  input  1  Delayed Read Data FIFO non-empty.
master_seeing_write_fence  input  1  Master reports that a write fence has been passed.
delayed_read_flush  output  1  one-cycle pulse; empty the Delayed Read Data FIFO.
dr_collision_event  output  1  one-cycle pulse; write hit during an outstanding read (possible corruption).
dr_discard_event  output  1  one-cycle pulse; discard timer expired.
dr_busy  output  1  high in any state other than IDLE.

Behaviour:
Reset:
- All outputs 0; latched address, command and byte-enable registers 0; state IDLE; counter 0; fence flag 0.
- Reset asserted mid-operation abandons the read with no flush pulse; the host side is reset separately.

States: IDLE, ISSUE, PENDING, READY, all one-hot.

Response latency:
- dr_resp_valid and dr_resp_hit are registered and appear exactly 1 cycle after tgt_read_req.

Match condition:
- tgt_read_address[31:2], tgt_read_command and tgt_read_cbe all equal the latched values.

IDLE:
- On tgt_read_req: latch address, command and cbe; respond with hit=0; go to ISSUE.

ISSUE:
- host_read_issue=1, held until the cycle host_read_issue_ack=1; then go to PENDING.
- Clear the fence flag on entry.
- Any tgt_read_req here responds with hit=0.

PENDING:
- Fence flag sets when master_seeing_write_fence=1; it is sticky.
- When delayed_read_data_available=1 and the fence flag is set (the flag may be setting in the same cycle), go to READY and clear the counter.
- Any tgt_read_req responds with hit=0.

READY:
- Counter increments every cycle.
- Matching tgt_read_req responds with hit=1 and stops the counter.
- Non-matching tgt_read_req responds with hit=0 and leaves the state unchanged.
- tgt_read_done: pulse delayed_read_flush to discard any prefetch; go to IDLE.
- Counter reaching DISCARD_CYCLES-1 with no hit: pulse dr_discard_event and delayed_read_flush; go to IDLE.

Write collision:
- tgt_write_seen in ISSUE, PENDING or READY pulses dr_collision_event.
- In PENDING or READY it also pulses delayed_read_flush and goes to ISSUE, re-issuing the same latched request.
- In ISSUE it stays in ISSUE; the request has not yet been enqueued.

Simultaneous events:
- tgt_write_seen with tgt_read_req (any non-IDLE state): the collision is processed and the read responds with hit=0.
- tgt_read_done with tgt_write_seen: done wins; go to IDLE with one flush pulse and no collision event.
- A matching tgt_read_req on the discard-expiry cycle: the request wins (hit=1, no discard).
- host_read_issue_ack with tgt_write_seen in ISSUE: go to PENDING; the collision pulse is still emitted.

Other rules:
- delayed_read_flush is at most one pulse per cycle.
- Latched registers hold until the next IDLE-state capture.
- The counter saturates and never wraps.

Test Plan:
1. Basic read: read A=0x1000_0040, cmd 6, cbe 0 -> resp hit=0 at +1; issue held until ack at +5. Then data_available and fence -> READY. Retry of the same read -> hit=1; read_done -> one flush pulse; busy=0.
2. Mismatch: in READY, read 0x1000_0044 -> hit=0 and state stays READY. Read with cbe=0xF to address A -> hit=0. Correct retry -> hit=1.
3. Collision: write pulse in READY -> collision and flush pulses; issue reasserts with address 0x1000_0040. Re-ack, data and fence -> READY again.
4. Discard: DISCARD_CYCLES=16; reach READY, no retry -> discard and flush pulses exactly 16 cycles after entering READY; IDLE. A new read at 0x2000_0000 is latched.
5. Ordering: data_available=1 but no fence -> stays PENDING and a retry gets hit=0. A one-cycle fence pulse -> READY next cycle.
6. Reset mid-PENDING: assert pci_reset_comb for 1 cycle -> next cycle all outputs 0, state IDLE; no flush pulse.

Source files
------------

// File: rtl/pci_blue_delayed_read_ctrl_if.sv
// Target/host/FIFO-side signal bundle for the delayed read controller.
// slave: controller view; master: Target/host/FIFO environment view.
interface pci_blue_delayed_read_ctrl_if;
  logic        tgt_read_req;
  logic [31:0] tgt_read_address;
  logic [3:0]  tgt_read_command;
  logic [3:0]  tgt_read_cbe;
  logic        tgt_write_seen;
  logic        tgt_read_done;
  logic        dr_resp_valid;
  logic        dr_resp_hit;
  logic        host_read_issue;
  logic        host_read_issue_ack;
  logic [31:0] host_read_address;
  logic [3:0]  host_read_command;
  logic [3:0]  host_read_cbe;
  logic        delayed_read_data_available;
  logic        master_seeing_write_fence;
  logic        delayed_read_flush;
  logic        dr_collision_event;
  logic        dr_discard_event;
  logic        dr_busy;

  modport slave (
    input  tgt_read_req,
    input  tgt_read_address,
    input  tgt_read_command,
    input  tgt_read_cbe,
    input  tgt_write_seen,
    input  tgt_read_done,
    output dr_resp_valid,
    output dr_resp_hit,
    output host_read_issue,
    input  host_read_issue_ack,
    output host_read_address,
    output host_read_command,
    output host_read_cbe,
    input  delayed_read_data_available,
    input  master_seeing_write_fence,
    output delayed_read_flush,
    output dr_collision_event,
    output dr_discard_event,
    output dr_busy
  );

  modport master (
    output tgt_read_req,
    output tgt_read_address,
    output tgt_read_command,
    output tgt_read_cbe,
    output tgt_write_seen,
    output tgt_read_done,
    input  dr_resp_valid,
    input  dr_resp_hit,
    input  host_read_issue,
    output host_read_issue_ack,
    input  host_read_address,
    input  host_read_command,
    input  host_read_cbe,
    output delayed_read_data_available,
    output master_seeing_write_fence,
    input  delayed_read_flush,
    input  dr_collision_event,
    input  dr_discard_event,
    input  dr_busy
  );
endinterface

// File: rtl/pci_blue_delayed_read_ctrl.sv
// Sequences the single outstanding PCI Delayed Read: latch, retry, issue,
// wait data+fence, complete; flush on write collision or discard timeout.
// Ports: pci_clk, pci_reset_comb (sync, active-high), bus (slave modport).
module pci_blue_delayed_read_ctrl #(
  parameter int DISCARD_CYCLES = 32768,
  parameter int TIMER_WIDTH    = 16
) (
  input logic                         pci_clk,
  input logic                         pci_reset_comb,
  pci_blue_delayed_read_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_ISSUE = 4'b0010,
    S_PEND  = 4'b0100,
    S_READY = 4'b1000
  } state_t;

  localparam logic [TIMER_WIDTH-1:0] CNT_LAST =
    TIMER_WIDTH'(DISCARD_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] CNT_MAX = '1;

  state_t state, state_n;

  logic [31:0] addr, addr_n;
  logic [3:0]  cmd, cmd_n;
  logic [3:0]  cbe, cbe_n;
  logic        fence, fence_n;
  logic        hit_taken, hit_taken_n;
  logic [TIMER_WIDTH-1:0] cnt, cnt_n;

  logic resp_valid, resp_valid_n;
  logic resp_hit, resp_hit_n;
  logic flush, flush_n;
  logic coll, coll_n;
  logic disc, disc_n;

  logic match;
  logic fence_set;

  // Byte offset bits are not part of the request identity.
  assign match = (bus.tgt_read_address[31:2] == addr[31:2])
              && (bus.tgt_read_command == cmd)
              && (bus.tgt_read_cbe == cbe);

  // Fence may arrive in the same cycle as the data.
  assign fence_set = fence | bus.master_seeing_write_fence;

  always_ff @(posedge pci_clk) begin
    if (pci_reset_comb) begin
      state      <= S_IDLE;
      addr       <= '0;
      cmd        <= '0;
      cbe        <= '0;
      fence      <= 1'b0;
      hit_taken  <= 1'b0;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      flush      <= 1'b0;
      coll       <= 1'b0;
      disc       <= 1'b0;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      cmd        <= cmd_n;
      cbe        <= cbe_n;
      fence      <= fence_n;
      hit_taken  <= hit_taken_n;
      cnt        <= cnt_n;
      resp_valid <= resp_valid_n;
      resp_hit   <= resp_hit_n;
      flush      <= flush_n;
      coll       <= coll_n;
      disc       <= disc_n;
    end
  end

  always_comb begin
    state_n      = state;
    addr_n       = addr;
    cmd_n        = cmd;
    cbe_n        = cbe;
    fence_n      = fence;
    hit_taken_n  = hit_taken;
    cnt_n        = cnt;
    resp_valid_n = bus.tgt_read_req;
    resp_hit_n   = 1'b0;
    flush_n      = 1'b0;
    coll_n       = 1'b0;
    disc_n       = 1'b0;

    unique case (1'b1)
      (state == S_IDLE): begin
        if (bus.tgt_read_req) begin
          addr_n  = bus.tgt_read_address;
          cmd_n   = bus.tgt_read_command;
          cbe_n   = bus.tgt_read_cbe;
          state_n = S_ISSUE;
        end
      end

      (state == S_ISSUE): begin
        fence_n = 1'b0;
        // Not enqueued yet, so nothing to flush.
        if (bus.tgt_write_seen) coll_n = 1'b1;
        if (bus.host_read_issue_ack) state_n = S_PEND;
      end

      (state == S_PEND): begin
        fence_n = fence_set;
        if (bus.tgt_write_seen) begin
          coll_n  = 1'b1;
          flush_n = 1'b1;
          state_n = S_ISSUE;
        end else if (bus.delayed_read_data_available
                     && fence_set) begin
          cnt_n       = '0;
          hit_taken_n = 1'b0;
          state_n     = S_READY;
        end
      end

      (state == S_READY): begin
        if (!hit_taken && cnt != CNT_MAX) cnt_n = cnt + 1'b1;
        if (bus.tgt_read_done) begin
          flush_n = 1'b1;
          state_n = S_IDLE;
        end else if (bus.tgt_write_seen) begin
          coll_n  = 1'b1;
          flush_n = 1'b1;
          state_n = S_ISSUE;
        end else if (bus.tgt_read_req && match) begin
          // A hit freezes the discard timer.
          resp_hit_n  = 1'b1;
          hit_taken_n = 1'b1;
          cnt_n       = cnt;
        end else if (!hit_taken && cnt == CNT_LAST) begin
          disc_n  = 1'b1;
          flush_n = 1'b1;
          state_n = S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

  assign bus.dr_resp_valid      = resp_valid;
  assign bus.dr_resp_hit        = resp_hit;
  assign bus.host_read_issue    = (state == S_ISSUE);
  assign bus.host_read_address  = addr;
  assign bus.host_read_command  = cmd;
  assign bus.host_read_cbe      = cbe;
  assign bus.delayed_read_flush = flush;
  assign bus.dr_collision_event = coll;
  assign bus.dr_discard_event   = disc;
  assign bus.dr_busy            = (state != S_IDLE);

endmodule

// File: tb/tb_pci_blue_delayed_read_ctrl.sv
// Directed bench for the delayed read controller.
// Small discard timer so the timeout path is reachable quickly.
module tb_pci_blue_delayed_read_ctrl;
  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  pci_blue_delayed_read_ctrl_if bus();

  pci_blue_delayed_read_ctrl #(
    .DISCARD_CYCLES(16),
    .TIMER_WIDTH(16)
  ) dut (
    .pci_clk(clk),
    .pci_reset_comb(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.tgt_read_req        = 1'b0;
    bus.tgt_write_seen      = 1'b0;
    bus.tgt_read_done       = 1'b0;
    bus.host_read_issue_ack = 1'b0;
    bus.master_seeing_write_fence = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a,
                    input logic [3:0] c,
                    input logic [3:0] b);
    bus.tgt_read_address = a;
    bus.tgt_read_command = c;
    bus.tgt_read_cbe     = b;
    bus.tgt_read_req     = 1'b1;
    tick();
    bus.tgt_read_req     = 1'b0;
  endtask

  // Read, ack, data+fence: ends on the cycle READY is entered.
  task automatic go_ready(input logic [31:0] a);
    rd(a, 4'h6, 4'h0);
    bus.host_read_issue_ack = 1'b1;
    tick();
    bus.host_read_issue_ack = 1'b0;
    bus.delayed_read_data_available = 1'b1;
    bus.master_seeing_write_fence   = 1'b1;
    tick();
    bus.delayed_read_data_available = 1'b0;
    bus.master_seeing_write_fence   = 1'b0;
  endtask

  initial begin
    logic early;
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    clr();
    bus.tgt_read_address = '0;
    bus.tgt_read_command = '0;
    bus.tgt_read_cbe     = '0;
    bus.delayed_read_data_available = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_valid", {31'd0, bus.dr_resp_valid}, 32'd0);
    chk("rst_issue", {31'd0, bus.host_read_issue}, 32'd0);
    chk("rst_addr", bus.host_read_address, 32'd0);
    chk("rst_flush", {31'd0, bus.delayed_read_flush}, 32'd0);
    chk("rst_busy", {31'd0, bus.dr_busy}, 32'd0);

    // 1: basic read
    rd(32'h1000_0040, 4'h6, 4'h0);
    chk("t1_valid", {31'd0, bus.dr_resp_valid}, 32'd1);
    chk("t1_hit0", {31'd0, bus.dr_resp_hit}, 32'd0);
    chk("t1_issue", {31'd0, bus.host_read_issue}, 32'd1);
    chk("t1_addr", bus.host_read_address, 32'h1000_0040);
    chk("t1_cmd", {28'd0, bus.host_read_command}, 32'd6);
    tick();
    tick();
    tick();
    chk("t1_issue_held", {31'd0, bus.host_read_issue}, 32'd1);
    bus.host_read_issue_ack = 1'b1;
    tick();
    bus.host_read_issue_ack = 1'b0;
    chk("t1_issue_drop", {31'd0, bus.host_read_issue}, 32'd0);
    bus.delayed_read_data_available = 1'b1;
    bus.master_seeing_write_fence   = 1'b1;
    tick();
    bus.delayed_read_data_available = 1'b0;
    bus.master_seeing_write_fence   = 1'b0;
    rd(32'h1000_0040, 4'h6, 4'h0);
    chk("t1_hit1", {30'd0, bus.dr_resp_valid, bus.dr_resp_hit}, 32'd3);
    bus.tgt_read_done = 1'b1;
    tick();
    bus.tgt_read_done = 1'b0;
    chk("t1_flush", {31'd0, bus.delayed_read_flush}, 32'd1);
    chk("t1_idle", {31'd0, bus.dr_busy}, 32'd0);
    tick();
    chk("t1_flush_once", {31'd0, bus.delayed_read_flush}, 32'd0);

    // 2: mismatches in READY
    go_ready(32'h1000_0040);
    rd(32'h1000_0044, 4'h6, 4'h0);
    chk("t2_addr_miss", {30'd0, bus.dr_resp_valid, bus.dr_resp_hit}, 32'd2);
    chk("t2_busy", {31'd0, bus.dr_busy}, 32'd1);
    rd(32'h1000_0040, 4'h6, 4'hF);
    chk("t2_cbe_miss", {30'd0, bus.dr_resp_valid, bus.dr_resp_hit}, 32'd2);
    rd(32'h1000_0040, 4'h6, 4'h0);
    chk("t2_hit", {30'd0, bus.dr_resp_valid, bus.dr_resp_hit}, 32'd3);
    bus.tgt_read_done = 1'b1;
    tick();
    bus.tgt_read_done = 1'b0;

    // 3: write collision in READY
    go_ready(32'h1000_0040);
    bus.tgt_write_seen = 1'b1;
    tick();
    bus.tgt_write_seen = 1'b0;
    chk("t3_coll", {31'd0, bus.dr_collision_event}, 32'd1);
    chk("t3_flush", {31'd0, bus.delayed_read_flush}, 32'd1);
    chk("t3_reissue", {31'd0, bus.host_read_issue}, 32'd1);
    chk("t3_addr", bus.host_read_address, 32'h1000_0040);
    tick();
    chk("t3_coll_once", {31'd0, bus.dr_collision_event}, 32'd0);
    bus.host_read_issue_ack = 1'b1;
    tick();
    bus.host_read_issue_ack = 1'b0;
    bus.delayed_read_data_available = 1'b1;
    bus.master_seeing_write_fence   = 1'b1;
    tick();
    bus.delayed_read_data_available = 1'b0;
    bus.master_seeing_write_fence   = 1'b0;
    rd(32'h1000_0040, 4'h6, 4'h0);
    chk("t3_hit", {30'd0, bus.dr_resp_valid, bus.dr_resp_hit}, 32'd3);
    bus.tgt_read_done = 1'b1;
    tick();
    bus.tgt_read_done = 1'b0;

    // 4: discard after 16 cycles in READY
    go_ready(32'h1000_0040);
    early = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      early = early | bus.dr_discard_event | ~bus.dr_busy;
    end
    chk("t4_no_early", {31'd0, early}, 32'd0);
    tick();
    chk("t4_discard", {31'd0, bus.dr_discard_event}, 32'd1);
    chk("t4_flush", {31'd0, bus.delayed_read_flush}, 32'd1);
    chk("t4_idle", {31'd0, bus.dr_busy}, 32'd0);
    rd(32'h2000_0000, 4'h6, 4'h0);
    chk("t4_new_addr", bus.host_read_address, 32'h2000_0000);

    // 5: data without fence stays pending
    bus.host_read_issue_ack = 1'b1;
    tick();
    bus.host_read_issue_ack = 1'b0;
    bus.delayed_read_data_available = 1'b1;
    tick();
    rd(32'h2000_0000, 4'h6, 4'h0);
    chk("t5_no_fence", {30'd0, bus.dr_resp_valid, bus.dr_resp_hit}, 32'd2);
    bus.master_seeing_write_fence = 1'b1;
    tick();
    bus.master_seeing_write_fence = 1'b0;
    bus.delayed_read_data_available = 1'b0;
    rd(32'h2000_0000, 4'h6, 4'h0);
    chk("t5_fenced_hit", {30'd0, bus.dr_resp_valid, bus.dr_resp_hit}, 32'd3);
    bus.tgt_read_done = 1'b1;
    tick();
    bus.tgt_read_done = 1'b0;

    // 6: reset while PENDING
    rd(32'h3000_0000, 4'h6, 4'h0);
    bus.host_read_issue_ack = 1'b1;
    tick();
    bus.host_read_issue_ack = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", {31'd0, bus.dr_busy}, 32'd0);
    chk("t6_flush", {31'd0, bus.delayed_read_flush}, 32'd0);
    chk("t6_addr", bus.host_read_address, 32'd0);

    // 7: done together with write: flush, no collision
    go_ready(32'h1000_0040);
    bus.tgt_read_done  = 1'b1;
    bus.tgt_write_seen = 1'b1;
    tick();
    clr();
    chk("t7_flush", {31'd0, bus.delayed_read_flush}, 32'd1);
    chk("t7_no_coll", {31'd0, bus.dr_collision_event}, 32'd0);
    chk("t7_idle", {31'd0, bus.dr_busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
